// File: rtl/fsm_input_cond.sv
// Input conditioning for the a/b/c control FSM:
// 2-flop sync, debounce, rise pulses, glitch counter.
module fsm_input_cond #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  input  logic       clr_glitch,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       a_rise,
  output logic       b_rise,
  output logic       c_rise,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DB_CYCLES - 1);

  logic [2:0]            raw;
  logic [2:0]            s1_q;
  logic [2:0]            s2_q;
  logic [2:0]            lvl_q;
  logic [2:0]            lvl_d;
  logic [2:0]            rise_q;
  logic [2:0]            rise_d;
  logic [2:0]            abort;
  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;
  logic [7:0]            glitch_q;
  logic [7:0]            glitch_d;
  logic [1:0]            n_abort;
  logic [8:0]            glitch_sum;

  assign raw = {raw_c, raw_b, raw_a};

  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    abort  = '0;
    cnt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (en) begin
        if (s2_q[i] == lvl_q[i]) begin
          abort[i] = (cnt_q[i] != '0);
        end else if (cnt_q[i] != LAST) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          lvl_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
        end
      end
    end
  end

  // up to three aborts per cycle; saturate instead of wrapping
  always_comb begin
    n_abort = 2'(abort[0]) + 2'(abort[1])
            + 2'(abort[2]);
    glitch_sum = {1'b0, glitch_q}
               + {7'b0, n_abort};
    if (clr_glitch)
      glitch_d = '0;
    else if (glitch_sum[8])
      glitch_d = 8'hFF;
    else
      glitch_d = glitch_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      lvl_q    <= '0;
      rise_q   <= '0;
      cnt_q    <= '0;
      glitch_q <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      lvl_q    <= lvl_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
    end
  end

  assign a          = lvl_q[0];
  assign b          = lvl_q[1];
  assign c          = lvl_q[2];
  assign a_rise     = rise_q[0];
  assign b_rise     = rise_q[1];
  assign c_rise     = rise_q[2];
  assign glitch_cnt = glitch_q;

endmodule
